// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: op classes, opcode constants and field/immediate helpers.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int RIDX_W = $clog2(NREG);

    typedef enum logic [3:0] {
        OP_LUI     = 4'd0,
        OP_AUIPC   = 4'd1,
        OP_JAL     = 4'd2,
        OP_JALR    = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_LOAD    = 4'd5,
        OP_STORE   = 4'd6,
        OP_OPIMM   = 4'd7,
        OP_OP      = 4'd8,
        OP_ILLEGAL = 4'd9
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic [6:0] opc_f(input logic [XLEN-1:0] i);
        return i[6:0];
    endfunction

    function automatic logic [RIDX_W-1:0] rd_f(input logic [XLEN-1:0] i);
        return i[11:7];
    endfunction

    function automatic logic [RIDX_W-1:0] rs1_f(input logic [XLEN-1:0] i);
        return i[19:15];
    endfunction

    function automatic logic [RIDX_W-1:0] rs2_f(input logic [XLEN-1:0] i);
        return i[24:20];
    endfunction

    function automatic logic [2:0] funct3_f(input logic [XLEN-1:0] i);
        return i[14:12];
    endfunction

    function automatic logic [XLEN-1:0] imm_i(input logic [XLEN-1:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [XLEN-1:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [XLEN-1:0] i);
        return {i[31:12], 12'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic op_e decode_op(input logic [6:0] opc);
        op_e op;
        case (opc)
            OPC_LUI:    op = OP_LUI;
            OPC_AUIPC:  op = OP_AUIPC;
            OPC_JAL:    op = OP_JAL;
            OPC_JALR:   op = OP_JALR;
            OPC_BRANCH: op = OP_BRANCH;
            OPC_LOAD:   op = OP_LOAD;
            OPC_STORE:  op = OP_STORE;
            OPC_OPIMM:  op = OP_OPIMM;
            OPC_OP:     op = OP_OP;
            default:    op = OP_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Fetch, execute and writeback signals of the decode/issue stage; master is the surrounding pipeline.
interface decode_issue_if;
    import riscv_pkg::*;

    logic                  if_valid;
    logic [XLEN-1:0]       if_instr;
    logic                  if_ready;
    logic                  flush;
    logic [RIDX_W-1:0]     rs1;
    logic [RIDX_W-1:0]     rs2;
    logic                  ex_valid;
    logic                  ex_ready;
    op_e                   ex_op;
    logic [2:0]            ex_funct3;
    logic                  ex_funct7b5;
    logic [RIDX_W-1:0]     ex_rd;
    logic [XLEN-1:0]       ex_imm;
    logic                  ex_illegal;
    logic                  wb_we;
    logic [RIDX_W-1:0]     wb_ws;

    modport master (
        output if_valid, if_instr, flush, ex_ready, wb_we, wb_ws,
        input  if_ready, rs1, rs2, ex_valid, ex_op, ex_funct3, ex_funct7b5,
               ex_rd, ex_imm, ex_illegal
    );

    modport slave (
        input  if_valid, if_instr, flush, ex_ready, wb_we, wb_ws,
        output if_ready, rs1, rs2, ex_valid, ex_op, ex_funct3, ex_funct7b5,
               ex_rd, ex_imm, ex_illegal
    );

endinterface

// File: rtl/decode_issue_scoreboard.sv
// Busy scoreboard: one bit per architectural register with a write in flight.
module decode_issue_scoreboard
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en_i,
    input  logic [RIDX_W-1:0] set_idx_i,
    input  logic              clr_en_i,
    input  logic [RIDX_W-1:0] clr_idx_i,
    input  logic [RIDX_W-1:0] rs1_i,
    input  logic [RIDX_W-1:0] rs2_i,
    input  logic [RIDX_W-1:0] rd_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic              rd_busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // A set on the same register as a writeback clear wins: the new write is still in flight.
    for (genvar i = 0; i < NREG; i++) begin : g_bit
        if (i == 0) begin : g_zero
            assign busy_d[i] = 1'b0;
        end else begin : g_reg
            assign busy_d[i] = (set_en_i && (set_idx_i == RIDX_W'(i))) ||
                               (busy_q[i] && !(clr_en_i && (clr_idx_i == RIDX_W'(i))));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy_o = busy_q[rs1_i];
    assign rs2_busy_o = busy_q[rs2_i];
    assign rd_busy_o  = busy_q[rd_i];

endmodule

// File: rtl/decode_issue.sv
// RV32I decode/issue stage: one-entry holding register, combinational decode, scoreboard-gated issue.
module decode_issue
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    decode_issue_if.slave bus
);

    logic              d_valid_q, d_valid_d;
    logic [XLEN-1:0]   d_instr_q, d_instr_d;

    op_e               op;
    logic              uses_rs1, uses_rs2, writes_rd;
    logic [XLEN-1:0]   imm;
    logic [RIDX_W-1:0] rs1_sel, rs2_sel, rd_sel;
    logic              rs1_busy, rs2_busy, rd_busy;
    logic              hazard, ex_valid, issue, accept, if_ready;

    always_comb begin
        op        = decode_op(opc_f(d_instr_q));
        uses_rs1  = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
        uses_rs2  = op inside {OP_BRANCH, OP_STORE, OP_OP};
        writes_rd = !(op inside {OP_BRANCH, OP_STORE, OP_ILLEGAL}) &&
                    (rd_f(d_instr_q) != '0);
        case (op)
            OP_JALR, OP_LOAD, OP_OPIMM: imm = imm_i(d_instr_q);
            OP_STORE:                   imm = imm_s(d_instr_q);
            OP_BRANCH:                  imm = imm_b(d_instr_q);
            OP_LUI, OP_AUIPC:           imm = imm_u(d_instr_q);
            OP_JAL:                     imm = imm_j(d_instr_q);
            default:                    imm = '0;
        endcase
    end

    // Selects are zeroed when unused or empty so x0 never looks busy and the RF sees 0.
    assign rs1_sel = (d_valid_q && uses_rs1)  ? rs1_f(d_instr_q) : '0;
    assign rs2_sel = (d_valid_q && uses_rs2)  ? rs2_f(d_instr_q) : '0;
    assign rd_sel  = (d_valid_q && writes_rd) ? rd_f(d_instr_q)  : '0;

    decode_issue_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (issue && writes_rd),
        .set_idx_i  (rd_sel),
        .clr_en_i   (bus.wb_we),
        .clr_idx_i  (bus.wb_ws),
        .rs1_i      (rs1_sel),
        .rs2_i      (rs2_sel),
        .rd_i       (rd_sel),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy)
    );

    // Registered busy only: a same-cycle writeback is not bypassed since RF data lands at this edge.
    assign hazard   = rs1_busy || rs2_busy || rd_busy;
    assign ex_valid = d_valid_q && !hazard && !bus.flush;
    assign issue    = ex_valid && bus.ex_ready;
    assign if_ready = !d_valid_q || issue;
    assign accept   = bus.if_valid && if_ready;

    always_comb begin
        d_valid_d = d_valid_q;
        d_instr_d = d_instr_q;
        if (accept) begin
            d_valid_d = 1'b1;
            d_instr_d = bus.if_instr;
        end else if (issue || bus.flush) begin
            d_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_valid_q <= 1'b0;
            d_instr_q <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            d_instr_q <= d_instr_d;
        end
    end

    assign bus.if_ready    = if_ready;
    assign bus.ex_valid    = ex_valid;
    assign bus.rs1         = rs1_sel;
    assign bus.rs2         = rs2_sel;
    assign bus.ex_rd       = rd_sel;
    assign bus.ex_op       = op;
    assign bus.ex_funct3   = funct3_f(d_instr_q);
    assign bus.ex_funct7b5 = d_instr_q[30];
    assign bus.ex_imm      = d_valid_q ? imm : '0;
    assign bus.ex_illegal  = d_valid_q && (op == OP_ILLEGAL);

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: decode vector table, directed hazard/flush/reset sequences, random run vs model.
module tb_decode_issue;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_issue_if bus();
    decode_issue dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] instr;
        op_e         op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        f7b5;
        logic        ill;
    } dec_t;

    int checks = 0;
    int failures = 0;
    dec_t vec[12];
    logic [4:0] inflight[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_ws    = '0;
    endtask

    task automatic check_dec(input string tag, input dec_t e);
        chk({tag, "_rs1"},   32'(bus.rs1),         32'(e.rs1));
        chk({tag, "_rs2"},   32'(bus.rs2),         32'(e.rs2));
        chk({tag, "_rd"},    32'(bus.ex_rd),       32'(e.rd));
        chk({tag, "_imm"},   bus.ex_imm,           e.imm);
        chk({tag, "_op"},    32'(bus.ex_op),       32'(e.op));
        chk({tag, "_f3"},    32'(bus.ex_funct3),   32'(e.f3));
        chk({tag, "_f7b5"},  32'(bus.ex_funct7b5), 32'(e.f7b5));
        chk({tag, "_ill"},   32'(bus.ex_illegal),  32'(e.ill));
    endtask

    function automatic bit in_q(input logic [4:0] r);
        foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Builds an instruction from randomly chosen fields; the chosen fields are the expected decode.
    function automatic dec_t gen_instr();
        dec_t d;
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [4:0]  r1 = 5'($urandom_range(0, 7));
        logic [4:0]  r2 = 5'($urandom_range(0, 7));
        logic [2:0]  f3 = 3'($urandom_range(0, 7));
        logic [31:0] rnd = $urandom;
        logic [11:0] i12 = rnd[11:0];
        logic [12:0] b13 = {rnd[12:1], 1'b0};
        logic [20:0] j21 = {rnd[20:1], 1'b0};
        logic [6:0]  opc;
        int k = $urandom_range(0, 9);
        d.rs1 = '0; d.rs2 = '0; d.rd = '0; d.imm = '0; d.ill = 1'b0;
        d.op = OP_ILLEGAL; d.instr = '0;
        case (k)
            0: begin d.op = OP_LUI;   d.instr = {rnd[31:12], rd, OPC_LUI};   d.rd = rd; d.imm = {rnd[31:12], 12'h000}; end
            1: begin d.op = OP_AUIPC; d.instr = {rnd[31:12], rd, OPC_AUIPC}; d.rd = rd; d.imm = {rnd[31:12], 12'h000}; end
            2: begin
                d.op = OP_JAL; d.rd = rd; d.imm = {{11{j21[20]}}, j21};
                d.instr = {j21[20], j21[10:1], j21[11], j21[19:12], rd, OPC_JAL};
            end
            3: begin d.op = OP_JALR;  d.instr = {i12, r1, f3, rd, OPC_JALR};  d.rs1 = r1; d.rd = rd; d.imm = {{20{i12[11]}}, i12}; end
            4: begin
                d.op = OP_BRANCH; d.rs1 = r1; d.rs2 = r2; d.imm = {{19{b13[12]}}, b13};
                d.instr = {b13[12], b13[10:5], r2, r1, f3, b13[4:1], b13[11], OPC_BRANCH};
            end
            5: begin d.op = OP_LOAD;  d.instr = {i12, r1, f3, rd, OPC_LOAD};  d.rs1 = r1; d.rd = rd; d.imm = {{20{i12[11]}}, i12}; end
            6: begin
                d.op = OP_STORE; d.rs1 = r1; d.rs2 = r2; d.imm = {{20{i12[11]}}, i12};
                d.instr = {i12[11:5], r2, r1, f3, i12[4:0], OPC_STORE};
            end
            7: begin d.op = OP_OPIMM; d.instr = {i12, r1, f3, rd, OPC_OPIMM}; d.rs1 = r1; d.rd = rd; d.imm = {{20{i12[11]}}, i12}; end
            8: begin d.op = OP_OP; d.instr = {1'b0, rnd[0], 5'b0, r2, r1, f3, rd, OPC_OP}; d.rs1 = r1; d.rs2 = r2; d.rd = rd; end
            default: begin
                do opc = 7'($urandom);
                while (opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                   OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP});
                d.op = OP_ILLEGAL; d.instr = {rnd[31:7], opc}; d.rs1 = d.instr[19:15]; d.ill = 1'b1;
            end
        endcase
        d.f3   = d.instr[14:12];
        d.f7b5 = d.instr[30];
        return d;
    endfunction

    initial begin
        dec_t held, cand;
        bit m_valid, hz, exp_ev, issue, exp_ir;
        logic [31:0] exp_busy;

        vec[0]  = '{32'h00500093, OP_OPIMM,   5'd0, 5'd0, 5'd1, 32'h00000005, 3'd0, 1'b0, 1'b0};
        vec[1]  = '{32'h00108133, OP_OP,      5'd1, 5'd1, 5'd2, 32'h00000000, 3'd0, 1'b0, 1'b0};
        vec[2]  = '{32'h123451B7, OP_LUI,     5'd0, 5'd0, 5'd3, 32'h12345000, 3'd5, 1'b0, 1'b0};
        vec[3]  = '{32'hFE000EE3, OP_BRANCH,  5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 3'd0, 1'b1, 1'b0};
        vec[4]  = '{32'h0001807F, OP_ILLEGAL, 5'd3, 5'd0, 5'd0, 32'h00000000, 3'd0, 1'b0, 1'b1};
        vec[5]  = '{32'h00512423, OP_STORE,   5'd2, 5'd5, 5'd0, 32'h00000008, 3'd2, 1'b0, 1'b0};
        vec[6]  = '{32'hFFF3A303, OP_LOAD,    5'd7, 5'd0, 5'd6, 32'hFFFFFFFF, 3'd2, 1'b1, 1'b0};
        vec[7]  = '{32'h001000EF, OP_JAL,     5'd0, 5'd0, 5'd1, 32'h00000800, 3'd0, 1'b0, 1'b0};
        vec[8]  = '{32'h00008067, OP_JALR,    5'd1, 5'd0, 5'd0, 32'h00000000, 3'd0, 1'b0, 1'b0};
        vec[9]  = '{32'hFFFFF217, OP_AUIPC,   5'd0, 5'd0, 5'd4, 32'hFFFFF000, 3'd7, 1'b1, 1'b0};
        vec[10] = '{32'h4034D413, OP_OPIMM,   5'd9, 5'd0, 5'd8, 32'h00000403, 3'd5, 1'b1, 1'b0};
        vec[11] = '{32'h00100293, OP_OPIMM,   5'd0, 5'd0, 5'd5, 32'h00000001, 3'd0, 1'b0, 1'b0};

        rst = 1'b0;
        idle();
        step(); step();
        chk("rst_if_ready", 32'(bus.if_ready),   32'd1);
        chk("rst_ex_valid", 32'(bus.ex_valid),   32'd0);
        chk("rst_rs1",      32'(bus.rs1),        32'd0);
        chk("rst_rs2",      32'(bus.rs2),        32'd0);
        chk("rst_ex_rd",    32'(bus.ex_rd),      32'd0);
        chk("rst_ex_imm",   bus.ex_imm,          32'd0);
        chk("rst_illegal",  32'(bus.ex_illegal), 32'd0);
        chk("rst_busy",     dut.u_sb.busy_q,     32'd0);
        @(negedge clk) rst = 1'b1;
        step();

        // Decode table: load, hold without issuing, then flush it away.
        for (int i = 0; i < 12; i++) begin
            bus.if_valid = 1'b1; bus.if_instr = vec[i].instr; bus.ex_ready = 1'b0;
            step();
            bus.if_valid = 1'b0;
            chk($sformatf("vec%0d_ex_valid", i), 32'(bus.ex_valid), 32'd1);
            check_dec($sformatf("vec%0d", i), vec[i]);
            bus.flush = 1'b1; #1;
            chk($sformatf("vec%0d_flush_ev", i), 32'(bus.ex_valid), 32'd0);
            step();
            bus.flush = 1'b0;
            chk($sformatf("vec%0d_empty", i), 32'(bus.if_ready), 32'd1);
            chk($sformatf("vec%0d_busy", i), dut.u_sb.busy_q, 32'd0);
        end

        // RAW: addi x1 then add x2,x1,x1 held until the cycle after writeback of x1.
        bus.if_valid = 1'b1; bus.if_instr = 32'h00500093; bus.ex_ready = 1'b1;
        step();
        bus.if_instr = 32'h00108133;
        chk("raw_addi_ev",  32'(bus.ex_valid), 32'd1);
        chk("raw_addi_rd",  32'(bus.ex_rd),    32'd1);
        chk("raw_addi_imm", bus.ex_imm,        32'd5);
        step();
        bus.if_valid = 1'b0;
        chk("raw_busy1",    dut.u_sb.busy_q,   32'h2);
        chk("raw_stall_ev", 32'(bus.ex_valid), 32'd0);
        chk("raw_stall_ir", 32'(bus.if_ready), 32'd0);
        step();
        chk("raw_stall2_ev", 32'(bus.ex_valid), 32'd0);
        bus.wb_we = 1'b1; bus.wb_ws = 5'd1; #1;
        chk("raw_nobypass_ev", 32'(bus.ex_valid), 32'd0);
        step();
        bus.wb_we = 1'b0;
        chk("raw_wb_busy", dut.u_sb.busy_q,   32'd0);
        chk("raw_go_ev",   32'(bus.ex_valid), 32'd1);
        chk("raw_go_rs1",  32'(bus.rs1),      32'd1);
        chk("raw_go_rs2",  32'(bus.rs2),      32'd1);
        chk("raw_go_rd",   32'(bus.ex_rd),    32'd2);
        step();
        chk("raw_add_busy", dut.u_sb.busy_q,   32'h4);
        chk("raw_add_ir",   32'(bus.if_ready), 32'd1);
        bus.wb_we = 1'b1; bus.wb_ws = 5'd2;
        step();
        bus.wb_we = 1'b0;
        chk("raw_clr_busy", dut.u_sb.busy_q, 32'd0);

        // Issue of x5 coinciding with a writeback clear of x5 leaves x5 busy.
        bus.if_valid = 1'b1; bus.if_instr = 32'h00100293; bus.ex_ready = 1'b1;
        step();
        bus.if_valid = 1'b0; bus.wb_we = 1'b1; bus.wb_ws = 5'd5; #1;
        chk("setclr_ev", 32'(bus.ex_valid), 32'd1);
        step();
        bus.wb_we = 1'b0;
        chk("setclr_busy", dut.u_sb.busy_q, 32'h20);
        bus.wb_we = 1'b1;
        step();
        bus.wb_we = 1'b0;
        chk("setclr_clr_busy", dut.u_sb.busy_q, 32'd0);

        // Flush of a stalled instruction: no issue, stage empties, scoreboard untouched.
        bus.if_valid = 1'b1; bus.if_instr = 32'h00500093; bus.ex_ready = 1'b1;
        step();
        bus.if_instr = 32'h00108133;
        step();
        bus.if_valid = 1'b0;
        bus.flush = 1'b1; #1;
        chk("flush_ev", 32'(bus.ex_valid), 32'd0);
        chk("flush_ir", 32'(bus.if_ready), 32'd0);
        step();
        bus.flush = 1'b0;
        chk("flush_empty_ir", 32'(bus.if_ready), 32'd1);
        chk("flush_empty_ev", 32'(bus.ex_valid), 32'd0);
        chk("flush_busy",     dut.u_sb.busy_q,   32'h2);

        // Reset while stalled: held instruction and busy bits drop immediately.
        bus.if_valid = 1'b1; bus.if_instr = 32'h00108133;
        step();
        bus.if_valid = 1'b0;
        chk("rststall_ev", 32'(bus.ex_valid), 32'd0);
        rst = 1'b0; #1;
        chk("rststall_busy", dut.u_sb.busy_q,   32'd0);
        chk("rststall_ir",   32'(bus.if_ready), 32'd1);
        chk("rststall_ev2",  32'(bus.ex_valid), 32'd0);
        idle();
        @(negedge clk) rst = 1'b1;
        step();

        // Random traffic against the in-flight-write model.
        m_valid = 1'b0;
        held = vec[0];
        inflight.delete();
        cand = gen_instr();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.if_valid = ($urandom_range(0, 3) != 0);
            bus.if_instr = cand.instr;
            bus.ex_ready = ($urandom_range(0, 3) != 0);
            bus.flush    = ($urandom_range(0, 29) == 0);
            if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                bus.wb_we = 1'b1;
                bus.wb_ws = inflight[$urandom_range(0, inflight.size() - 1)];
            end else if ($urandom_range(0, 9) == 0) begin
                bus.wb_we = 1'b1;
                bus.wb_ws = 5'($urandom_range(0, 7));
            end else begin
                bus.wb_we = 1'b0;
                bus.wb_ws = 5'($urandom);
            end
            @(negedge clk);
            hz     = in_q(held.rs1) || in_q(held.rs2) || in_q(held.rd);
            exp_ev = m_valid && !hz && !bus.flush;
            issue  = exp_ev && bus.ex_ready;
            exp_ir = !m_valid || issue;
            exp_busy = '0;
            foreach (inflight[i]) exp_busy[inflight[i]] = 1'b1;
            chk("rnd_ex_valid", 32'(bus.ex_valid), 32'(exp_ev));
            chk("rnd_if_ready", 32'(bus.if_ready), 32'(exp_ir));
            chk("rnd_busy",     dut.u_sb.busy_q,   exp_busy);
            if (m_valid) begin
                check_dec("rnd", held);
            end else begin
                chk("rnd_idle_rs1", 32'(bus.rs1),        32'd0);
                chk("rnd_idle_rs2", 32'(bus.rs2),        32'd0);
                chk("rnd_idle_rd",  32'(bus.ex_rd),      32'd0);
                chk("rnd_idle_imm", bus.ex_imm,          32'd0);
                chk("rnd_idle_ill", 32'(bus.ex_illegal), 32'd0);
            end
            if (bus.wb_we) begin
                for (int i = inflight.size() - 1; i >= 0; i--)
                    if (inflight[i] == bus.wb_ws) inflight.delete(i);
            end
            if (issue && held.rd != 5'd0) inflight.push_back(held.rd);
            if (bus.if_valid && exp_ir) begin
                held = cand; m_valid = 1'b1; cand = gen_instr();
            end else if (issue || bus.flush) begin
                m_valid = 1'b0;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
